sw_conditioner: RTL

SW_CONDITIONER -- requirements
Module: sw_conditioner

---
 rtl/sw_conditioner.sv | 91 +++++++++
 1 files changed

// File: rtl/sw_conditioner.sv
// Per-channel switch conditioner: SYNC_STAGES-flop synchroniser followed by a counting debouncer.
// Change-pulse outputs (changed/any_changed) are only built when SW_CONDITIONER_CHANGED_EN is defined.
module sw_conditioner #(
    parameter int               WIDTH           = 16,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 65536,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] changed,
    output logic             any_changed
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("sw_conditioner: SYNC_STAGES must be 2..4");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_deb
        $error("sw_conditioner: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  sync_w;
    logic [WIDTH-1:0]                  stable_q;
    logic [WIDTH-1:0]                  stable_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_d;

    // Stage 0 captures the raw input; the highest index is the synchronised level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VALUE}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
        end
    end

    assign sync_w = sync_q[SYNC_STAGES-1];

    // A differing level must persist on DEBOUNCE_CYCLES consecutive edges; the counter saturates by accepting.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync_w[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_TERM) begin
                stable_d[i] = sync_w[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable_q <= RESET_VALUE;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign out = stable_q;

`ifdef SW_CONDITIONER_CHANGED_EN
    logic [WIDTH-1:0] changed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            changed_q <= '0;
        end else begin
            changed_q <= stable_d ^ stable_q;
        end
    end

    assign changed = changed_q;
`else
    assign changed = '0;
`endif

    assign any_changed = |changed;

endmodule
